// File: rtl/hash_digest_reader_if.sv
// ---------------------------------------------------------------------------
// hash_digest_reader_if
// Byte stream carrying the digest from the reader to a downstream consumer.
//   out_data   [7:0]  digest byte                         (master -> slave)
//   out_valid         out_data holds a valid byte         (master -> slave)
//   out_last          current byte is final digest byte   (master -> slave)
//   out_ready         consumer accepts the byte           (slave  -> master)
// A byte moves on a rising edge where out_valid and out_ready are both high.
// ---------------------------------------------------------------------------
interface hash_digest_reader_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/hash_digest_reader.sv
// ---------------------------------------------------------------------------
// hash_digest_reader
// Copies the final sponge lanes into a local buffer once the hash core
// signals completion, then streams the digest out one byte at a time,
// little-endian (byte k = buffer bits 8k+7:8k).
//   ex_clk     single clock, rising edge
//   ovr_rst_n  asynchronous active-low reset
//   dig_start  one-cycle pulse: sponge state is final and readable
//   lane_in    sponge lane addressed by lane_idx (combinational read)
//   lane_idx   lane address towards the sponge state
//   dout       byte stream (out_data/out_valid/out_last/out_ready)
//   busy       high while fetching or sending
//   dig_cnt    digests delivered in the current group of three (0..2)
//   seq_done   one-cycle pulse after the third digest of a group completes
//   ovf_err    sticky: dig_start seen while busy
// ---------------------------------------------------------------------------
module hash_digest_reader #(
    parameter int DIG_LANES = 4
) (
    input  logic                 ex_clk,
    input  logic                 ovr_rst_n,
    input  logic                 dig_start,
    input  logic [63:0]          lane_in,
    output logic [1:0]           lane_idx,
    hash_digest_reader_if.master dout,
    output logic                 busy,
    output logic [1:0]           dig_cnt,
    output logic                 seq_done,
    output logic                 ovf_err
);

    localparam int         NBYTES    = 8 * DIG_LANES;
    localparam logic [4:0] LAST_BYTE = 5'(NBYTES - 1);
    localparam logic [1:0] LAST_LANE = 2'(DIG_LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND
    } state_t;

    state_t                   state_reg;
    logic [1:0]               lane_idx_reg;
    logic [4:0]               byte_idx_reg;
    logic [64*DIG_LANES-1:0]  buffer_reg;
    logic [7:0]               out_data_reg;
    logic                     out_valid_reg;
    logic                     out_last_reg;
    logic                     busy_reg;
    logic [1:0]               dig_cnt_reg;
    logic                     seq_done_reg;
    logic                     ovf_err_reg;
    logic [4:0]               byte_next;

    assign byte_next = byte_idx_reg + 5'd1;

    always_ff @(posedge ex_clk or negedge ovr_rst_n) begin
        if (!ovr_rst_n) begin
            state_reg     <= ST_IDLE;
            lane_idx_reg  <= 2'd0;
            byte_idx_reg  <= 5'd0;
            buffer_reg    <= '0;
            out_data_reg  <= 8'd0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            dig_cnt_reg   <= 2'd0;
            seq_done_reg  <= 1'b0;
            ovf_err_reg   <= 1'b0;
        end else begin
            seq_done_reg <= 1'b0;

            // Any start outside IDLE is dropped; this includes a start that
            // coincides with the final byte transfer, since we are still in SEND.
            if (dig_start && state_reg != ST_IDLE) begin
                ovf_err_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    lane_idx_reg <= 2'd0;
                    if (dig_start) begin
                        state_reg <= ST_FETCH;
                        busy_reg  <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    buffer_reg[64*lane_idx_reg +: 64] <= lane_in;
                    if (lane_idx_reg == LAST_LANE) begin
                        state_reg    <= ST_SEND;
                        lane_idx_reg <= 2'd0;
                        byte_idx_reg <= 5'd0;
                    end else begin
                        lane_idx_reg <= lane_idx_reg + 2'd1;
                    end
                end

                ST_SEND: begin
                    if (!out_valid_reg) begin
                        // First SEND cycle loads the output register from the
                        // buffer, which by now holds every lane including the
                        // one written on the FETCH->SEND edge.
                        out_data_reg  <= buffer_reg[8*byte_idx_reg +: 8];
                        out_last_reg  <= (byte_idx_reg == LAST_BYTE);
                        out_valid_reg <= 1'b1;
                    end else if (dout.out_ready) begin
                        if (out_last_reg) begin
                            state_reg     <= ST_IDLE;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                            byte_idx_reg  <= 5'd0;
                            if (dig_cnt_reg == 2'd2) begin
                                dig_cnt_reg  <= 2'd0;
                                seq_done_reg <= 1'b1;
                            end else begin
                                dig_cnt_reg <= dig_cnt_reg + 2'd1;
                            end
                        end else begin
                            byte_idx_reg <= byte_next;
                            out_data_reg <= buffer_reg[8*byte_next +: 8];
                            out_last_reg <= (byte_next == LAST_BYTE);
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign lane_idx       = lane_idx_reg;
    assign dout.out_data  = out_data_reg;
    assign dout.out_valid = out_valid_reg;
    assign dout.out_last  = out_last_reg;
    assign busy           = busy_reg;
    assign dig_cnt        = dig_cnt_reg;
    assign seq_done       = seq_done_reg;
    assign ovf_err        = ovf_err_reg;

endmodule

// File: doc/hash_digest_reader.md
HASH_DIGEST_READER -- requirements
Module: hash_digest_reader

Interface
REQ-001 Parameter DIG_LANES, default 4, the number of 64-bit sponge lanes read per digest (legal range 1..4); digest length is 8*DIG_LANES bytes.
REQ-002 ex_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 ovr_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 dig_start  input  1  one-cycle pulse from the hash control side: sponge state is final and readable.
REQ-005 lane_in  input  64  sponge lane currently addressed by lane_idx; combinational read, valid in the same cycle.
REQ-006 lane_idx  output  2  lane address driven to the sponge state.
REQ-007 out_data  output  8  digest byte.
REQ-008 out_valid  output  1  out_data holds a valid byte.
REQ-009 out_ready  input  1  downstream accepts the byte.
REQ-010 out_last  output  1  current byte is the final byte of the digest.
REQ-011 busy  output  1  high in FETCH or SEND.
REQ-012 dig_cnt  output  2  digests fully delivered in the current 3-digest sequence (0..2).
REQ-013 seq_done  output  1  one-cycle pulse when the third digest of a sequence completes.
REQ-014 ovf_err  output  1  sticky flag: dig_start arrived while busy.

Function
REQ-015 FSM states: IDLE, FETCH, SEND; no other state is reachable.
REQ-016 IDLE: lane_idx=0, out_valid=0, busy=0; an edge with dig_start=1 moves to FETCH with lane_idx=0.
REQ-017 FETCH: each edge stores lane_in into buffer slot lane_idx (bits 64*lane_idx+63:64*lane_idx) and increments lane_idx.
REQ-018 FETCH: the edge that stores lane DIG_LANES-1 moves to SEND with byte_idx=0 and lane_idx=0.
REQ-019 Latency: out_valid rises DIG_LANES+1 edges after the edge that samples dig_start (5 edges at default).
REQ-020 SEND: out_valid=1; out_data = buffer byte byte_idx (little-endian: byte k = bits 8k+7:8k).
REQ-021 Transfer occurs on an edge with out_valid=1 and out_ready=1; on a transfer, byte_idx increments.
REQ-022 out_data, out_valid and out_last hold stable while out_valid=1 and out_ready=0.
REQ-023 out_last=1 only in SEND with byte_idx=8*DIG_LANES-1.
REQ-024 Transfer of the last byte moves to IDLE and increments dig_cnt.
REQ-025 When the last byte completes with dig_cnt=2, dig_cnt returns to 0 and seq_done pulses high for exactly one cycle, the cycle after that transfer edge.
REQ-026 dig_start while busy is ignored (no restart, no buffer change) and sets ovf_err=1.
REQ-027 ovf_err is cleared only by reset.
REQ-028 dig_start on the same edge as the final-byte transfer is treated as busy: it is ignored and sets ovf_err.
REQ-029 busy=1 exactly in FETCH and SEND.
REQ-030 A DIG_LANES value outside 1..4 is a configuration error and is not required to function.

Reset
REQ-031 On ovr_rst_n=0, immediately and independent of ex_clk: state=IDLE; lane_idx=0; byte_idx=0; buffer=0; out_data=0; out_valid=0; out_last=0; busy=0; dig_cnt=0; seq_done=0; ovf_err=0.
REQ-032 A reset asserted mid-FETCH or mid-SEND discards the partial digest, and no further byte is presented.
REQ-033 After ovr_rst_n deasserts, the first dig_start sampled on a rising edge is honoured.

Verification
REQ-034 Basic digest: lanes 0x0706050403020100, 0x0F0E..08, 0x1716..10, 0x1F1E..18; dig_start pulse; out_ready=1 -> out_valid rises 5 edges after the start edge, bytes 0x00..0x1F delivered in order, out_last only on 0x1F, then busy=0 and dig_cnt=1.
REQ-035 Backpressure: same stimulus; out_ready toggles 0/1 pseudo-randomly -> every byte still delivered exactly once, in order, with out_data stable while stalled.
REQ-036 Sequence wrap: three digests back-to-back -> dig_cnt goes 1, 2, 0; a single seq_done pulse follows the 96th byte transfer.
REQ-037 Overflow: dig_start re-pulsed during SEND at byte 10 -> ovf_err=1, byte stream unaffected, and ovf_err remains 1 after the digest completes.
REQ-038 Reset mid-SEND at byte 20 -> all outputs at reset values; a new dig_start yields a complete 32-byte digest starting at byte 0.
